// File: rtl/sem_mailbox.sv
// Semaphore mailbox: DEPTH-entry FIFO that answers a producer controller's write
// handshake and a consumer controller's read handshake, with sticky error flags.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module sem_mailbox #(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned DEPTH      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         wr_valid,
    output logic                         wr_empty,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    input  logic                         rd_read,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic                         err_clr,
    output logic                         ovf_err,
    output logic                         udf_err
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wp_q, wp_d;
    logic [PtrW-1:0]       rp_q, rp_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  not_full;
    logic                  not_empty;
    logic                  push;
    logic                  pop;

    assign not_full  = (count_q < CntW'(DEPTH));
    assign not_empty = (count_q != '0);

    // A pop on a full queue frees the slot the same cycle, so the write still lands.
    assign pop  = rd_read && not_empty;
    assign push = wr_valid && (not_full || pop);

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q & ~err_clr;
        udf_d   = udf_q & ~err_clr;

        if (push) begin
            wp_d = (wp_q == PtrW'(DEPTH - 1)) ? '0 : wp_q + PtrW'(1);
        end
        if (pop) begin
            rp_d = (rp_q == PtrW'(DEPTH - 1)) ? '0 : rp_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // Setting after the clear term makes a new error win over err_clr.
        if (wr_valid && !push) begin
            ovf_d = 1'b1;
        end
        if (rd_read && !not_empty) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (push && (wp_q == PtrW'(i))) begin
                    mem_q[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (rp_q == PtrW'(i)) begin
                rd_data = mem_q[i];
            end
        end
    end

    assign wr_empty = not_full;
    assign rd_valid = not_empty;
    assign count    = count_q;
    assign ovf_err  = ovf_q;
    assign udf_err  = udf_q;

endmodule

// File: tb/tb_sem_mailbox.sv
// Directed bench for sem_mailbox: three instances (DEPTH 1, 2, 3) driven by one
// linear stimulus sequence, each checkpoint an immediate assertion.
module tb_sem_mailbox;

    logic       clk;
    logic       rst;

    logic [7:0] wd1, wd2, wd3;
    logic       wv1, wv2, wv3;
    logic       rr1, rr2, rr3;
    logic       ec1, ec2, ec3;

    logic [7:0] rdat1, rdat2, rdat3;
    logic       rv1, rv2, rv3;
    logic       we1, we2, we3;
    logic [0:0] cnt1;
    logic [1:0] cnt2, cnt3;
    logic       ovf1, ovf2, ovf3;
    logic       udf1, udf2, udf3;

    int n_cmp = 0;
    int n_err = 0;

    sem_mailbox #(.DATA_WIDTH(8), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .wr_data(wd1), .wr_valid(wv1), .wr_empty(we1),
        .rd_data(rdat1), .rd_valid(rv1), .rd_read(rr1), .count(cnt1),
        .err_clr(ec1), .ovf_err(ovf1), .udf_err(udf1)
    );

    sem_mailbox #(.DATA_WIDTH(8), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .wr_data(wd2), .wr_valid(wv2), .wr_empty(we2),
        .rd_data(rdat2), .rd_valid(rv2), .rd_read(rr2), .count(cnt2),
        .err_clr(ec2), .ovf_err(ovf2), .udf_err(udf2)
    );

    sem_mailbox #(.DATA_WIDTH(8), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .wr_data(wd3), .wr_valid(wv3), .wr_empty(we3),
        .rd_data(rdat3), .rd_valid(rv3), .rd_read(rr3), .count(cnt3),
        .err_clr(ec3), .ovf_err(ovf3), .udf_err(udf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push3(input logic [7:0] d);
        wd3 = d; wv3 = 1'b1;
        tick();
        wv3 = 1'b0;
    endtask

    task automatic pop3();
        rr3 = 1'b1;
        tick();
        rr3 = 1'b0;
    endtask

    task automatic push2(input logic [7:0] d);
        wd2 = d; wv2 = 1'b1;
        tick();
        wv2 = 1'b0;
    endtask

    task automatic pop2();
        rr2 = 1'b1;
        tick();
        rr2 = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        {wd1, wd2, wd3} = '0;
        {wv1, wv2, wv3} = '0;
        {rr1, rr2, rr3} = '0;
        {ec1, ec2, ec3} = '0;

        // Reset state
        #1;
        chk("rst_cnt_in_reset", 32'(cnt1), 0);
        #7 rst = 1'b1;
        tick();
        chk("rst_rv", 32'(rv1), 0);
        chk("rst_we", 32'(we1), 1);
        chk("rst_cnt", 32'(cnt1), 0);
        chk("rst_rdata", 32'(rdat1), 0);
        chk("rst_ovf", 32'(ovf1), 0);
        chk("rst_udf", 32'(udf1), 0);
        chk("rst_d3_we", 32'(we3), 1);

        // DEPTH=1 semaphore
        wd1 = 8'h01; wv1 = 1'b1;
        tick();
        wv1 = 1'b0;
        chk("d1_push_rv", 32'(rv1), 1);
        chk("d1_push_rdata", 32'(rdat1), 8'h01);
        chk("d1_push_we", 32'(we1), 0);
        chk("d1_push_cnt", 32'(cnt1), 1);
        wd1 = 8'h7E; wv1 = 1'b1;
        tick();
        wv1 = 1'b0;
        chk("d1_full_drop_rdata", 32'(rdat1), 8'h01);
        chk("d1_full_drop_ovf", 32'(ovf1), 1);
        rr1 = 1'b1;
        tick();
        rr1 = 1'b0;
        chk("d1_pop_rv", 32'(rv1), 0);
        chk("d1_pop_we", 32'(we1), 1);
        chk("d1_pop_cnt", 32'(cnt1), 0);

        // DEPTH=3 ordering and pointer wrap
        push3(8'hA1); chk("d3_cnt_1", 32'(cnt3), 1);
        chk("d3_head_a1", 32'(rdat3), 8'hA1);
        push3(8'h02); chk("d3_cnt_2", 32'(cnt3), 2);
        push3(8'hB3); chk("d3_cnt_3", 32'(cnt3), 3);
        chk("d3_full_we", 32'(we3), 0);
        chk("d3_pop1_data", 32'(rdat3), 8'hA1);
        pop3();       chk("d3_cnt_4", 32'(cnt3), 2);
        push3(8'h04); chk("d3_cnt_5", 32'(cnt3), 3);
        chk("d3_pop2_data", 32'(rdat3), 8'h02);
        pop3();       chk("d3_cnt_6", 32'(cnt3), 2);
        chk("d3_pop3_data", 32'(rdat3), 8'hB3);
        pop3();       chk("d3_cnt_7", 32'(cnt3), 1);
        chk("d3_pop4_data", 32'(rdat3), 8'h04);
        pop3();       chk("d3_cnt_8", 32'(cnt3), 0);
        chk("d3_empty_rv", 32'(rv3), 0);
        chk("d3_no_err", 32'({ovf3, udf3}), 0);

        // DEPTH=2 overflow and error clear
        push2(8'h11);
        push2(8'h22);
        push2(8'h33);
        chk("d2_ovf_cnt", 32'(cnt2), 2);
        chk("d2_ovf_flag", 32'(ovf2), 1);
        chk("d2_ovf_udf", 32'(udf2), 0);
        chk("d2_ovf_head", 32'(rdat2), 8'h11);
        pop2();
        chk("d2_ovf_pop1", 32'(rdat2), 8'h22);
        chk("d2_ovf_sticky", 32'(ovf2), 1);
        pop2();
        chk("d2_ovf_cnt0", 32'(cnt2), 0);
        ec2 = 1'b1;
        tick();
        ec2 = 1'b0;
        chk("d2_ovf_clr", 32'(ovf2), 0);

        // Empty pop with simultaneous push
        wd2 = 8'h55; wv2 = 1'b1; rr2 = 1'b1;
        tick();
        wv2 = 1'b0; rr2 = 1'b0;
        chk("d2_udf_flag", 32'(udf2), 1);
        chk("d2_udf_cnt", 32'(cnt2), 1);
        chk("d2_udf_rdata", 32'(rdat2), 8'h55);
        // Clear and a fresh underflow in the same cycle: set wins
        pop2();
        ec2 = 1'b1; rr2 = 1'b1;
        tick();
        ec2 = 1'b0; rr2 = 1'b0;
        chk("d2_set_wins", 32'(udf2), 1);
        ec2 = 1'b1;
        tick();
        ec2 = 1'b0;
        chk("d2_udf_clr", 32'(udf2), 0);

        // Full with simultaneous push and pop
        push2(8'hA0);
        push2(8'hA1);
        chk("d2_full_cnt", 32'(cnt2), 2);
        wd2 = 8'hA2; wv2 = 1'b1; rr2 = 1'b1;
        tick();
        wv2 = 1'b0; rr2 = 1'b0;
        chk("d2_pp_cnt", 32'(cnt2), 2);
        chk("d2_pp_head", 32'(rdat2), 8'hA1);
        chk("d2_pp_no_ovf", 32'(ovf2), 0);
        pop2();
        chk("d2_pp_pop2", 32'(rdat2), 8'hA2);
        chk("d2_pp_cnt1", 32'(cnt2), 1);

        // Asynchronous reset mid-stream
        push2(8'hC5);
        chk("d2_pre_rst_cnt", 32'(cnt2), 2);
        #2 rst = 1'b0;
        #1;
        chk("d2_arst_cnt", 32'(cnt2), 0);
        chk("d2_arst_rv", 32'(rv2), 0);
        chk("d2_arst_rdata", 32'(rdat2), 0);
        #2 rst = 1'b1;
        push2(8'h5A);
        chk("d2_post_rst_cnt", 32'(cnt2), 1);
        chk("d2_post_rst_rdata", 32'(rdat2), 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
